// File: rtl/conv_buf_pkg.sv
// Shared definitions for the convolution sample buffer and its window reader.
// Holds default geometry, the stride legality check and the tap-pair type.
package conv_buf_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 8;
    localparam int DEFAULT_BUFFER_SIZE  = 4;
    localparam int DEFAULT_BUFFER_WIDTH = 2;

    function automatic bit stride_legal(input int stride);
        return (stride == 1) || (stride == 2);
    endfunction

    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0] tap0;
        logic [DEFAULT_DATA_WIDTH-1:0] tap1;
    } tap_pair_t;

endpackage

// File: rtl/conv_window_reader_wrap_ptr.sv
// Modulo-2^WIDTH pointer with a variable step; wraps naturally on overflow.
module wrap_ptr #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] ptr
);

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + step;
        end
    end

endmodule

// File: rtl/conv_window_reader.sv
// Write/read controller for the 2-read-port sample buffer; emits adjacent
// sample pairs (x[n], x[n+1]) to the MAC stage with valid/ready.
module conv_window_reader
    import conv_buf_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int BUFFER_SIZE  = DEFAULT_BUFFER_SIZE,
    parameter int BUFFER_WIDTH = DEFAULT_BUFFER_WIDTH,
    parameter int STRIDE       = 1
) (
    input  logic                    clk,
    input  logic                    aclr,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    buf_we,
    output logic [BUFFER_WIDTH-1:0] buf_waddr,
    output logic [DATA_WIDTH-1:0]   buf_wdata,
    output logic [BUFFER_WIDTH-1:0] buf_raddr1,
    output logic [BUFFER_WIDTH-1:0] buf_raddr2,
    input  logic [DATA_WIDTH-1:0]   buf_rdata1,
    input  logic [DATA_WIDTH-1:0]   buf_rdata2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_tap0,
    output logic [DATA_WIDTH-1:0]   out_tap1,
    output logic [15:0]             pair_count
);

    if (!stride_legal(STRIDE)) begin : g_bad_stride
        $error("conv_window_reader: STRIDE must be 1 or 2");
    end

    localparam logic [BUFFER_WIDTH:0]   FULL_COUNT = (BUFFER_WIDTH+1)'(BUFFER_SIZE);
    localparam logic [BUFFER_WIDTH:0]   POP_COUNT  = (BUFFER_WIDTH+1)'(STRIDE);
    localparam logic [BUFFER_WIDTH:0]   ONE_COUNT  = (BUFFER_WIDTH+1)'(1);
    localparam logic [BUFFER_WIDTH:0]   PAIR_MIN   = (BUFFER_WIDTH+1)'(2);
    localparam logic [BUFFER_WIDTH-1:0] WR_STEP    = BUFFER_WIDTH'(1);
    localparam logic [BUFFER_WIDTH-1:0] RD_STEP    = BUFFER_WIDTH'(STRIDE);

    logic [BUFFER_WIDTH:0]   count_reg, count_next;
    logic [15:0]             pair_count_reg;
    logic [BUFFER_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                    push, pop;
    tap_pair_t               taps;

    // Handshake flags come only from the registered occupancy, so neither
    // ready nor valid combinationally depends on the other side.
    assign in_ready  = ~aclr & (count_reg < FULL_COUNT);
    assign out_valid = ~aclr & (count_reg >= PAIR_MIN);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_next = count_reg;
        if (push) begin
            count_next = count_next + ONE_COUNT;
        end
        if (pop) begin
            count_next = count_next - POP_COUNT;
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            count_reg      <= '0;
            pair_count_reg <= '0;
        end else if (flush) begin
            count_reg      <= '0;
            pair_count_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (pop && (pair_count_reg != 16'hFFFF)) begin
                pair_count_reg <= pair_count_reg + 16'd1;
            end
        end
    end

    wrap_ptr #(.WIDTH(BUFFER_WIDTH)) u_wr_ptr (
        .clk  (clk),
        .aclr (aclr),
        .clr  (flush),
        .en   (push),
        .step (WR_STEP),
        .ptr  (wr_ptr)
    );

    wrap_ptr #(.WIDTH(BUFFER_WIDTH)) u_rd_ptr (
        .clk  (clk),
        .aclr (aclr),
        .clr  (flush),
        .en   (pop),
        .step (RD_STEP),
        .ptr  (rd_ptr)
    );

    assign buf_we     = push;
    assign buf_waddr  = wr_ptr;
    assign buf_wdata  = in_data;
    assign buf_raddr1 = rd_ptr;
    assign buf_raddr2 = rd_ptr + WR_STEP;

    assign taps.tap0  = buf_rdata1;
    assign taps.tap1  = buf_rdata2;
    assign out_tap0   = taps.tap0;
    assign out_tap1   = taps.tap1;
    assign pair_count = pair_count_reg;

endmodule

// File: tb/tb_conv_window_reader.sv
// Two readers (STRIDE 1 and 2) each with its own buffer, checked every cycle
// against a sample-queue model of the window semantics.
module tb_conv_window_reader;

    localparam int DW = 8;
    localparam int BS = 4;
    localparam int BW = 2;

    logic          clk = 1'b0;
    logic          aclr = 1'b1;
    logic          flush = 1'b0;
    logic [1:0]    in_valid = '0;
    logic [1:0]    out_ready = '0;
    logic [DW-1:0] in_data = '0;

    logic [1:0]    in_ready_w, out_valid_w, buf_we_w;
    logic [15:0]   pc_w [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int ST = gi + 1;

        logic          we, ir, ov;
        logic [BW-1:0] wa, ra1, ra2;
        logic [DW-1:0] wd, rd1, rd2, t0, t1;
        logic [15:0]   pc;
        logic [DW-1:0] mem [BS];

        conv_window_reader #(
            .DATA_WIDTH(DW), .BUFFER_SIZE(BS), .BUFFER_WIDTH(BW), .STRIDE(ST)
        ) dut (
            .clk        (clk),
            .aclr       (aclr),
            .flush      (flush),
            .in_valid   (in_valid[gi]),
            .in_ready   (ir),
            .in_data    (in_data),
            .buf_we     (we),
            .buf_waddr  (wa),
            .buf_wdata  (wd),
            .buf_raddr1 (ra1),
            .buf_raddr2 (ra2),
            .buf_rdata1 (rd1),
            .buf_rdata2 (rd2),
            .out_valid  (ov),
            .out_ready  (out_ready[gi]),
            .out_tap0   (t0),
            .out_tap1   (t1),
            .pair_count (pc)
        );

        always @(posedge clk) begin
            if (we) mem[wa] <= wd;
        end
        assign rd1 = mem[ra1];
        assign rd2 = mem[ra2];

        assign in_ready_w[gi]  = ir;
        assign out_valid_w[gi] = ov;
        assign buf_we_w[gi]    = we;
        assign pc_w[gi]        = pc;

        // Reference: the buffer is a FIFO of samples; a pair is the two oldest.
        int q[$];
        int pcm = 0;

        always @(posedge clk or posedge aclr) begin
            if (aclr) begin
                q.delete();
                pcm <= 0;
            end else if (flush) begin
                q.delete();
                pcm <= 0;
            end else begin : model_step
                automatic int sz = q.size();
                if (sz < BS && in_valid[gi]) q.push_back(int'(in_data));
                if (sz >= 2 && out_ready[gi]) begin
                    $display("s%0d pair (%0d,%0d) n=%0d", ST, q[0], q[1], pcm + 1);
                    for (int k = 0; k < ST; k++) void'(q.pop_front());
                    if (pcm != 65535) pcm <= pcm + 1;
                end
            end
        end

        always @(negedge clk) begin : model_check
            automatic bit eir = !aclr && (q.size() < BS);
            automatic bit eov = !aclr && (q.size() >= 2);
            check_val($sformatf("s%0d_in_ready", ST), 32'(ir), 32'(eir));
            check_val($sformatf("s%0d_out_valid", ST), 32'(ov), 32'(eov));
            check_val($sformatf("s%0d_buf_we", ST), 32'(we), 32'(in_valid[gi] && eir));
            check_val($sformatf("s%0d_pair_count", ST), 32'(pc), 32'(pcm));
            if (eov) begin
                check_val($sformatf("s%0d_tap0", ST), 32'(t0), 32'(q[0]));
                check_val($sformatf("s%0d_tap1", ST), 32'(t1), 32'(q[1]));
            end
        end
    end

    task automatic drive(input logic [1:0] v, input logic [7:0] d, input logic [1:0] r, input bit f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #3 aclr = 1'b0;
        @(posedge clk);
        #1;

        // first pair appears after the second push and is held until popped
        drive(2'b11, 8'd10, 2'b00, 1'b0);
        drive(2'b11, 8'd20, 2'b00, 1'b0);
        repeat (3) drive(2'b00, 8'd0, 2'b00, 1'b0);
        repeat (2) drive(2'b00, 8'd0, 2'b11, 1'b0);
        drive(2'b00, 8'd0, 2'b00, 1'b1);

        for (int i = 1; i <= 5; i++) drive(2'b11, 8'(i), 2'b11, 1'b0);
        repeat (3) drive(2'b00, 8'd0, 2'b11, 1'b0);
        drive(2'b00, 8'd0, 2'b00, 1'b1);

        for (int i = 1; i <= 6; i++) drive(2'b10, 8'(i), 2'b11, 1'b0);
        repeat (3) drive(2'b00, 8'd0, 2'b11, 1'b0);
        drive(2'b00, 8'd0, 2'b00, 1'b1);

        // fill to full with the consumer stalled, then release one pop
        for (int i = 0; i < 6; i++) drive(2'b11, 8'(40 + i), 2'b00, 1'b0);
        drive(2'b11, 8'd50, 2'b11, 1'b0);
        repeat (2) drive(2'b11, 8'd51, 2'b00, 1'b0);
        drive(2'b00, 8'd0, 2'b00, 1'b1);

        for (int i = 0; i < 3 * BS; i++) drive(2'b11, 8'(60 + i), 2'b11, 1'b0);
        repeat (4) drive(2'b00, 8'd0, 2'b11, 1'b0);

        for (int i = 0; i < 400; i++)
            drive(2'($urandom), 8'($urandom), 2'($urandom), ($urandom_range(0, 31) == 0));

        // flush with push and pop both active
        repeat (3) drive(2'b11, 8'd90, 2'b00, 1'b0);
        drive(2'b11, 8'd99, 2'b11, 1'b1);
        check_val("flush_out_valid", 32'(out_valid_w), 32'd0);
        check_val("flush_pc0", 32'(pc_w[0]), 32'd0);
        check_val("flush_pc1", 32'(pc_w[1]), 32'd0);
        drive(2'b00, 8'd0, 2'b00, 1'b0);

        // asynchronous reset mid-stream
        repeat (3) drive(2'b11, 8'd77, 2'b11, 1'b0);
        in_valid  = 2'b11;
        out_ready = 2'b00;
        @(posedge clk);
        #3 aclr = 1'b1;
        #1;
        check_val("aclr_in_ready", 32'(in_ready_w), 32'd0);
        check_val("aclr_out_valid", 32'(out_valid_w), 32'd0);
        check_val("aclr_buf_we", 32'(buf_we_w), 32'd0);
        check_val("aclr_pc0", 32'(pc_w[0]), 32'd0);
        check_val("aclr_pc1", 32'(pc_w[1]), 32'd0);
        @(posedge clk);
        #3 aclr = 1'b0;
        in_valid = 2'b00;
        @(posedge clk);
        #1;
        repeat (3) drive(2'b00, 8'd0, 2'b11, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
